mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbiter for the single unified instruction/data memory (`MA`). It shares one memory port between two requesters: the core (ControlFSM fetch/load/store path) and an external requester (program loader / debug DMA). Per cycle it grants at most one requester, tracks ownership, enforces a starvation bound and an external lock, and returns registered read data. When the core is not granted, its `core_gnt` is low and the ControlFSM must hold its state.

## Interface
- `MEM_SIZE`, 1024: memory depth in 32-bit words. Must match `MA`'s `SIZE`.
- `MAX_CORE_STREAK`, 4: maximum consecutive contended core grants before the external requester is forced through. Range 1..15.
- `clk` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `core_req` / `ext_req` in 1: access request. Held with its address/data stable until granted.
- `core_we` / `ext_we` in 1: write (1) or read (0).
- `core_addr` / `ext_addr` in 32: byte address.
- `core_wdata` / `ext_wdata` in 32: write data.
- `ext_lock` in 1: when high and ext is granted, ext keeps exclusive ownership.
- `core_gnt` / `ext_gnt` out 1: combinational; access performed this cycle.
- `core_rvalid` / `ext_rvalid` out 1: registered; read data valid (cycle after read grant).
- `rdata` out 32: registered read data, shared by both requesters.
- `mem_a` out 32, `mem_wd` out 32, `mem_we` out 1: drive `MA` `A`/`WD`/`WE`.
- `mem_rd` in 32: `MA` `RD`, combinational from `mem_a`.
- `err` out 1: registered. Present only with `MEM_ARB_BOUNDS_CHECK_EN`.

## Operation
- States: `ARB_OWNER__NONE`, `ARB_OWNER__CORE`, `ARB_OWNER__EXT`. The state records the owner of the previous cycle's grant.
- Selection each cycle, first match wins:
  1. State EXT with `ext_lock`=1 → ext only. Core is blocked even if ext_req=0; memory is idle.
  2. Both requesting and `streak == MAX_CORE_STREAK` → ext.
  3. `core_req` → core.
  4. `ext_req` → ext.
  5. Otherwise none.
- Next state:
  - Owner of this cycle's grant, or NONE if nothing was granted.
  - Exception: stays EXT while `ext_lock`=1, even with no grant.
- `streak` (4-bit):
  - Increments on a core grant while `ext_req`=1.
  - Clears on any ext grant or when `ext_req`=0.
  - Saturates at `MAX_CORE_STREAK`.
- Memory drive:
  - `mem_a`/`mem_wd` muxed from the winner; core fields when none is granted.
  - `mem_we` = winner's `we` & grant.
- Read return:
  - On a read grant, `mem_rd` is captured into `rdata`.
  - The winner's `rvalid` pulses for exactly 1 cycle next.
  - `rdata` holds its value otherwise.
- Writes produce no `rvalid`.

## Timing
- Grant to memory access: same cycle (0 latency).
- Read data: 1 cycle after grant.
- Back-to-back grants are allowed every cycle, including alternating owners. `rvalid` of cycle N and a grant in cycle N+1 may coincide.
- While `reset`=1: `core_gnt`=`ext_gnt`=0, `mem_we`=0.
- On the first edge with reset: state=NONE, streak=0, rvalid=0, rdata=0, err=0.
- Reset mid-lock releases the lock. Reset mid-read drops the pending `rvalid`.
- `ext_lock` deasserted: core is eligible in the same cycle.
- `ext_lock` asserted while core owns: no effect until ext is next granted.

## Configuration
- `MEM_ARB_BOUNDS_CHECK_EN` defined:
  - A granted access with `addr[31:2] >= MEM_SIZE` is out of range. It is still granted, but `mem_we` is forced 0.
  - For a read, `rdata` is set to 0 and `rvalid` still pulses.
  - `err` pulses 1 cycle after the grant.
- Undefined: no check; `err` port absent; the address passes through unchanged.

## Structure
- Add `arb_owner_t` (2-bit enum, `ARB_OWNER__NONE`/`__CORE`/`__EXT`) to `src/types.svh` alongside the existing `adr_src_t` etc.
- One sub-module, `mem_arb_pick`: combinational. Takes reqs, lock, state and streak; returns the winner.

## Test plan
- Core only: read at 0x10 with memory word 0xDEADBEEF → `core_gnt`=1 same cycle; next cycle `core_rvalid`=1, `rdata`=0xDEADBEEF.
- Both requesting continuously, `MAX_CORE_STREAK`=4 → grants in order C,C,C,C,E,C,C,C,C,E…
- Ext write 0x12345678 to 0x40 with `ext_lock`=1 for 3 cycles, core requesting → ext owns, `core_gnt`=0 throughout. Core is granted the cycle lock drops; a later core read of 0x40 returns 0x12345678.
- Reset asserted while lock held and a read is pending → next cycle both gnts 0, rvalids 0, state NONE. Core is granted on the first cycle after reset.
- (`MEM_ARB_BOUNDS_CHECK_EN`, `MEM_SIZE`=1024) core write to 0x1000 → `mem_we`=0, `err`=1 next cycle. The word at 0x0 is unchanged.
- Alternating core read / ext read every cycle → each `rvalid` is routed to the correct requester with matching data, with no dropped cycles.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the unified-memory arbiter.
// The address range check is used only when MEM_ARB_BOUNDS_CHECK_EN is defined.
package mem_arbiter_pkg;

    localparam int unsigned StreakW = 4;

    typedef enum logic [1:0] {
        ARB_OWNER__NONE = 2'd0,
        ARB_OWNER__CORE = 2'd1,
        ARB_OWNER__EXT  = 2'd2
    } arb_owner_t;

    // The word index lies past the end of a MEM_SIZE-word memory.
    function automatic logic addr_oob(input logic [31:0] addr, input int unsigned mem_size);
        return {2'b00, addr[31:2]} >= mem_size;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester, memory and read-return signals of the arbiter.
// The err signal is present only when MEM_ARB_BOUNDS_CHECK_EN is defined.
interface mem_arbiter_if;

    logic        core_req;
    logic        core_we;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic        core_gnt;
    logic        core_rvalid;

    logic        ext_req;
    logic        ext_we;
    logic [31:0] ext_addr;
    logic [31:0] ext_wdata;
    logic        ext_lock;
    logic        ext_gnt;
    logic        ext_rvalid;

    logic [31:0] rdata;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;
`ifdef MEM_ARB_BOUNDS_CHECK_EN
    logic        err;
`endif

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        output ext_req, ext_we, ext_addr, ext_wdata, ext_lock,
        output mem_rd,
        input  core_gnt, core_rvalid, ext_gnt, ext_rvalid, rdata,
        input  mem_a, mem_wd, mem_we
`ifdef MEM_ARB_BOUNDS_CHECK_EN
        , input err
`endif
    );

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        input  ext_req, ext_we, ext_addr, ext_wdata, ext_lock,
        input  mem_rd,
        output core_gnt, core_rvalid, ext_gnt, ext_rvalid, rdata,
        output mem_a, mem_wd, mem_we
`ifdef MEM_ARB_BOUNDS_CHECK_EN
        , output err
`endif
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the core and the external requester.
module mem_arb_pick
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_CORE_STREAK = 4
) (
    input  logic               core_req,
    input  logic               ext_req,
    input  logic               ext_lock,
    input  arb_owner_t         state,
    input  logic [StreakW-1:0] streak,
    output arb_owner_t         winner
);

    localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_CORE_STREAK);

    always_comb begin
        winner = ARB_OWNER__NONE;
        if (state == ARB_OWNER__EXT && ext_lock) begin
            // A locked owner keeps the port even while idle.
            winner = ext_req ? ARB_OWNER__EXT : ARB_OWNER__NONE;
        end else if (core_req && ext_req && streak == StreakMax) begin
            winner = ARB_OWNER__EXT;
        end else if (core_req) begin
            winner = ARB_OWNER__CORE;
        end else if (ext_req) begin
            winner = ARB_OWNER__EXT;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between the core and an external requester.
// Define MEM_ARB_BOUNDS_CHECK_EN to block out-of-range writes and report them on err.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MEM_SIZE        = 1024,
    parameter int unsigned MAX_CORE_STREAK = 4
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);

    localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_CORE_STREAK);

    arb_owner_t         state_q, state_d, winner;
    logic [StreakW-1:0] streak_q, streak_d;
    logic               core_rvalid_q, ext_rvalid_q;
    logic [31:0]        rdata_q, rdata_d;
    logic               core_gnt, ext_gnt, any_gnt, sel_we, oob;

    mem_arb_pick #(
        .MAX_CORE_STREAK(MAX_CORE_STREAK)
    ) u_pick (
        .core_req(bus.core_req),
        .ext_req (bus.ext_req),
        .ext_lock(bus.ext_lock),
        .state   (state_q),
        .streak  (streak_q),
        .winner  (winner)
    );

    assign core_gnt = !reset && winner == ARB_OWNER__CORE;
    assign ext_gnt  = !reset && winner == ARB_OWNER__EXT;
    assign any_gnt  = core_gnt || ext_gnt;

    // With no grant the core fields stay on the bus.
    assign bus.mem_a  = (winner == ARB_OWNER__EXT) ? bus.ext_addr  : bus.core_addr;
    assign bus.mem_wd = (winner == ARB_OWNER__EXT) ? bus.ext_wdata : bus.core_wdata;
    assign sel_we     = (winner == ARB_OWNER__EXT) ? bus.ext_we    : bus.core_we;

`ifdef MEM_ARB_BOUNDS_CHECK_EN
    logic err_q;
    assign oob     = addr_oob(bus.mem_a, MEM_SIZE);
    assign bus.err = err_q;
`else
    logic unused_mem_size;
    assign unused_mem_size = ^MEM_SIZE;
    assign oob             = 1'b0;
`endif

    assign bus.mem_we      = any_gnt && sel_we && !oob;
    assign bus.core_gnt    = core_gnt;
    assign bus.ext_gnt     = ext_gnt;
    assign bus.core_rvalid = core_rvalid_q;
    assign bus.ext_rvalid  = ext_rvalid_q;
    assign bus.rdata       = rdata_q;

    always_comb begin
        state_d  = any_gnt ? winner : ARB_OWNER__NONE;
        streak_d = streak_q;
        rdata_d  = rdata_q;
        if (bus.ext_lock && (state_q == ARB_OWNER__EXT || winner == ARB_OWNER__EXT)) begin
            state_d = ARB_OWNER__EXT;
        end
        if (ext_gnt || !bus.ext_req) begin
            streak_d = '0;
        end else if (core_gnt && streak_q < StreakMax) begin
            streak_d = streak_q + 1'b1;
        end
        if (any_gnt && !sel_we) begin
            rdata_d = oob ? 32'h0 : bus.mem_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ARB_OWNER__NONE;
            streak_q      <= '0;
            core_rvalid_q <= 1'b0;
            ext_rvalid_q  <= 1'b0;
            rdata_q       <= 32'h0;
`ifdef MEM_ARB_BOUNDS_CHECK_EN
            err_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            streak_q      <= streak_d;
            core_rvalid_q <= core_gnt && !bus.core_we;
            ext_rvalid_q  <= ext_gnt && !bus.ext_we;
            rdata_q       <= rdata_d;
`ifdef MEM_ARB_BOUNDS_CHECK_EN
            err_q         <= any_gnt && oob;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter against a cycle-level reference model.
// Also exercises the out-of-range path when MEM_ARB_BOUNDS_CHECK_EN is defined.
module tb_mem_arbiter;

    localparam int unsigned MemSize   = 1024;
    localparam int          MaxStreak = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .MEM_SIZE       (MemSize),
        .MAX_CORE_STREAK(MaxStreak)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Memory seen by the DUT, and the reference copy the model keeps.
    logic [31:0] mem     [MemSize];
    logic [31:0] ref_mem [MemSize];
    assign bus.mem_rd = mem[bus.mem_a[11:2]];
    always @(posedge clk) if (bus.mem_we) mem[bus.mem_a[11:2]] <= bus.mem_wd;

    int n_cmp = 0;
    int n_mis = 0;

    // Model state: 0 none, 1 core, 2 ext.
    int          m_owner, m_streak;
    logic        m_core_rv, m_ext_rv, m_err;
    logic [31:0] m_rdata;
    logic        obs_core_gnt, obs_ext_gnt, obs_mem_we;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner   = 0;
        m_streak  = 0;
        m_core_rv = 1'b0;
        m_ext_rv  = 1'b0;
        m_err     = 1'b0;
        m_rdata   = 32'h0;
    endtask

    task automatic model_cycle(output int w);
        logic [31:0] a, wd;
        logic        we, oob;
        check_eq("core_rvalid", 32'(bus.core_rvalid), 32'(m_core_rv));
        check_eq("ext_rvalid", 32'(bus.ext_rvalid), 32'(m_ext_rv));
        check_eq("rdata", bus.rdata, m_rdata);
`ifdef MEM_ARB_BOUNDS_CHECK_EN
        check_eq("err", 32'(bus.err), 32'(m_err));
`endif
        if (reset) w = 0;
        else if (m_owner == 2 && bus.ext_lock) w = bus.ext_req ? 2 : 0;
        else if (bus.core_req && bus.ext_req && m_streak >= MaxStreak) w = 2;
        else if (bus.core_req) w = 1;
        else if (bus.ext_req) w = 2;
        else w = 0;
        a   = (w == 2) ? bus.ext_addr : bus.core_addr;
        wd  = (w == 2) ? bus.ext_wdata : bus.core_wdata;
        we  = (w == 2) ? bus.ext_we : bus.core_we;
        oob = 1'b0;
`ifdef MEM_ARB_BOUNDS_CHECK_EN
        oob = (a >> 2) >= 32'(MemSize);
`endif
        obs_core_gnt = bus.core_gnt;
        obs_ext_gnt  = bus.ext_gnt;
        obs_mem_we   = bus.mem_we;
        check_eq("core_gnt", 32'(bus.core_gnt), 32'(w == 1));
        check_eq("ext_gnt", 32'(bus.ext_gnt), 32'(w == 2));
        check_eq("mem_we", 32'(bus.mem_we), 32'(w != 0 && we && !oob));
        if (w != 0) check_eq("mem_a", bus.mem_a, a);
        else if (!reset) check_eq("mem_a_idle", bus.mem_a, bus.core_addr);
        if (w != 0 && we && !oob) check_eq("mem_wd", bus.mem_wd, wd);
        if (reset) begin
            model_reset();
            return;
        end
        m_core_rv = (w == 1) && !we;
        m_ext_rv  = (w == 2) && !we;
        m_err     = (w != 0) && oob;
        if (w != 0 && !we) m_rdata = oob ? 32'h0 : ref_mem[a[11:2]];
        if (w != 0 && we && !oob) ref_mem[a[11:2]] = wd;
        m_owner = (bus.ext_lock && (m_owner == 2 || w == 2)) ? 2 : w;
        if (w == 2 || !bus.ext_req) m_streak = 0;
        else if (w == 1 && m_streak < MaxStreak) m_streak++;
    endtask

    task automatic cycle(output int w);
        @(negedge clk);
        model_cycle(w);
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input logic req, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata);
        bus.core_req   = req;
        bus.core_we    = we;
        bus.core_addr  = addr;
        bus.core_wdata = wdata;
    endtask

    task automatic set_ext(input logic req, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata);
        bus.ext_req   = req;
        bus.ext_we    = we;
        bus.ext_addr  = addr;
        bus.ext_wdata = wdata;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = 32'($urandom_range(0, 15)) << 2;
`ifdef MEM_ARB_BOUNDS_CHECK_EN
        if ($urandom_range(0, 15) == 0) a = 32'h1000 + a;
`endif
        return a;
    endfunction

    initial begin
        int w;
        for (int i = 0; i < int'(MemSize); i++) begin
            mem[i]     = 32'(i) * 32'h0101_0101 ^ 32'hA5A5_0000;
            ref_mem[i] = mem[i];
        end
        mem[4]       = 32'hDEAD_BEEF;
        ref_mem[4]   = 32'hDEAD_BEEF;
        reset        = 1'b1;
        bus.ext_lock = 1'b0;
        set_core(1'b1, 1'b0, 32'h10, 32'h0);
        set_ext(1'b1, 1'b0, 32'h14, 32'h0);
        @(posedge clk);
        #1;
        model_reset();
        cycle(w);  // still in reset: no grants, cleared registers
        reset = 1'b0;
        set_ext(1'b0, 1'b0, 32'h0, 32'h0);

        // Core read of a known word.
        cycle(w);
        check_eq("t1_gnt", 32'(obs_core_gnt), 32'd1);
        check_eq("t1_rvalid", 32'(bus.core_rvalid), 32'd1);
        check_eq("t1_rdata", bus.rdata, 32'hDEAD_BEEF);
        set_core(1'b0, 1'b0, 32'h0, 32'h0);
        cycle(w);

        // Continuous contention: C,C,C,C,E repeating.
        set_core(1'b1, 1'b0, 32'h20, 32'h0);
        set_ext(1'b1, 1'b0, 32'h24, 32'h0);
        for (int i = 0; i < 10; i++) begin
            cycle(w);
            check_eq("streak_seq", obs_ext_gnt ? 32'd2 : (obs_core_gnt ? 32'd1 : 32'd0),
                     (i % 5 == 4) ? 32'd2 : 32'd1);
        end
        set_core(1'b0, 1'b0, 32'h0, 32'h0);
        set_ext(1'b0, 1'b0, 32'h0, 32'h0);
        cycle(w);

        // Locked ext write, core blocked until the lock drops.
        bus.ext_lock = 1'b1;
        set_ext(1'b1, 1'b1, 32'h40, 32'h1234_5678);
        cycle(w);
        check_eq("lock_ext_gnt", 32'(obs_ext_gnt), 32'd1);
        set_ext(1'b0, 1'b0, 32'h0, 32'h0);
        set_core(1'b1, 1'b0, 32'h40, 32'h0);
        for (int i = 0; i < 2; i++) begin
            cycle(w);
            check_eq("lock_core_blk", 32'(obs_core_gnt), 32'd0);
        end
        bus.ext_lock = 1'b0;
        cycle(w);
        check_eq("unlock_core_gnt", 32'(obs_core_gnt), 32'd1);
        check_eq("unlock_rdata", bus.rdata, 32'h1234_5678);
        set_core(1'b0, 1'b0, 32'h0, 32'h0);

        // Reset while locked with a read in flight.
        bus.ext_lock = 1'b1;
        set_ext(1'b1, 1'b0, 32'h44, 32'h0);
        cycle(w);
        set_ext(1'b0, 1'b0, 32'h0, 32'h0);
        set_core(1'b1, 1'b0, 32'h48, 32'h0);
        reset = 1'b1;
        cycle(w);
        check_eq("rst_core_rv", 32'(bus.core_rvalid), 32'd0);
        check_eq("rst_ext_rv", 32'(bus.ext_rvalid), 32'd0);
        reset = 1'b0;
        cycle(w);
        check_eq("post_rst_gnt", 32'(obs_core_gnt), 32'd1);
        bus.ext_lock = 1'b0;
        set_core(1'b0, 1'b0, 32'h0, 32'h0);

        // Alternating single-requester reads.
        for (int i = 0; i < 8; i++) begin
            set_core(i % 2 == 0, 1'b0, 32'($urandom_range(0, 15)) << 2, 32'h0);
            set_ext(i % 2 == 1, 1'b0, 32'($urandom_range(0, 15)) << 2, 32'h0);
            cycle(w);
        end
        set_ext(1'b0, 1'b0, 32'h0, 32'h0);

`ifdef MEM_ARB_BOUNDS_CHECK_EN
        set_core(1'b1, 1'b1, 32'h1000, 32'hFFFF_FFFF);
        cycle(w);
        check_eq("oob_mem_we", 32'(obs_mem_we), 32'd0);
        check_eq("oob_err", 32'(bus.err), 32'd1);
        check_eq("oob_mem0", mem[0], ref_mem[0]);
`endif
        set_core(1'b0, 1'b0, 32'h0, 32'h0);
        cycle(w);

        // Random traffic; requests stay stable until granted.
        for (int i = 0; i < 3000; i++) begin
            cycle(w);
            if (w == 1 || !bus.core_req)
                set_core($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), rand_addr(),
                         $urandom);
            if (w == 2 || !bus.ext_req)
                set_ext($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), rand_addr(),
                        $urandom);
            if ($urandom_range(0, 7) == 0) bus.ext_lock = ~bus.ext_lock;
            reset = ($urandom_range(0, 99) == 0);
        end
        reset = 1'b0;
        cycle(w);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
